// File: rtl/wavetable_voice_mixer_pkg.sv
// rtl/wavetable_voice_mixer_pkg.sv - shared FSM states, config select codes and clog2 helper
package wavetable_voice_mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VOICE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] CFG_INC  = 2'd0;
    localparam logic [1:0] CFG_VOL  = 2'd1;
    localparam logic [1:0] CFG_WAVE = 2'd2;
    localparam logic [1:0] CFG_EN   = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/wavetable_voice_mixer_if.sv
// rtl/wavetable_voice_mixer_if.sv - voice configuration write bus
interface wavetable_voice_mixer_if #(
    parameter int CV_W    = 1,
    parameter int PHASE_W = 16
);
    logic               cfg_we;
    logic [CV_W-1:0]    cfg_voice;
    logic [1:0]         cfg_sel;
    logic [PHASE_W-1:0] cfg_data;

    modport master (output cfg_we, output cfg_voice, output cfg_sel, output cfg_data);
    modport slave  (input  cfg_we, input  cfg_voice, input  cfg_sel, input  cfg_data);
endinterface

// File: rtl/wavetable_voice_mixer_regs.sv
// rtl/wavetable_voice_mixer_regs.sv - per-voice register file with write decode and phase advance
module wavetable_voice_mixer_regs
    import wavetable_voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 2,
    parameter int WSEL_W     = 2,
    parameter int PHASE_W    = 16,
    parameter int VOL_W      = 4,
    parameter int CV_W       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wavetable_voice_mixer_if.slave cfg,
    input  logic [CV_W-1:0]       i_rd_voice,
    input  logic                  i_adv,
    output logic [PHASE_W-1:0]    o_phase,
    output logic [VOL_W-1:0]      o_vol,
    output logic [WSEL_W-1:0]     o_wave,
    output logic                  o_en
);

    logic [PHASE_W-1:0] r_inc   [NUM_VOICES];
    logic [PHASE_W-1:0] r_phase [NUM_VOICES];
    logic [VOL_W-1:0]   r_vol   [NUM_VOICES];
    logic [WSEL_W-1:0]  r_wave  [NUM_VOICES];
    logic               r_en    [NUM_VOICES];
    logic               w_wr_ok;

    assign w_wr_ok = cfg.cfg_we && (int'(cfg.cfg_voice) < NUM_VOICES);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_inc[i]   <= '0;
                r_phase[i] <= '0;
                r_vol[i]   <= '0;
                r_wave[i]  <= '0;
                r_en[i]    <= 1'b0;
            end
        end else begin
            if (i_adv)
                r_phase[i_rd_voice] <= r_phase[i_rd_voice] + r_inc[i_rd_voice];
            // A 0->1 enable retriggers from phase 0; advance cannot collide since the voice was off.
            if (w_wr_ok) begin
                case (cfg.cfg_sel)
                    CFG_INC:  r_inc[cfg.cfg_voice]  <= cfg.cfg_data;
                    CFG_VOL:  r_vol[cfg.cfg_voice]  <= cfg.cfg_data[VOL_W-1:0];
                    CFG_WAVE: r_wave[cfg.cfg_voice] <= cfg.cfg_data[WSEL_W-1:0];
                    default: begin
                        if (cfg.cfg_data[0] && !r_en[cfg.cfg_voice])
                            r_phase[cfg.cfg_voice] <= '0;
                        r_en[cfg.cfg_voice] <= cfg.cfg_data[0];
                    end
                endcase
            end
        end
    end

    assign o_phase = r_phase[i_rd_voice];
    assign o_vol   = r_vol[i_rd_voice];
    assign o_wave  = r_wave[i_rd_voice];
    assign o_en    = r_en[i_rd_voice];

endmodule

// File: rtl/wavetable_voice_mixer.sv
// rtl/wavetable_voice_mixer.sv - time-multiplexed wavetable voices mixed into one sample per tick
module wavetable_voice_mixer
    import wavetable_voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 2,
    parameter int ROM_AW     = 4,
    parameter int WSEL_W     = 2,
    parameter int SAMPLE_W   = 8,
    parameter int PHASE_W    = 16,
    parameter int VOL_W      = 4,
    parameter int OUT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_sample_tick,
    wavetable_voice_mixer_if.slave    cfg,
    output logic [WSEL_W+ROM_AW-1:0]  o_rom_addr,
    input  logic [SAMPLE_W-1:0]       i_rom_data,
    output logic [OUT_W-1:0]          o_sample_out,
    output logic                      o_sample_valid,
    output logic                      o_busy,
    output logic                      o_overrun
);

    localparam int CV_W   = (clog2(NUM_VOICES) > 0) ? clog2(NUM_VOICES) : 1;
    localparam int PROD_W = SAMPLE_W + VOL_W;
    localparam int ACC_W  = PROD_W + clog2(NUM_VOICES);
    localparam logic [CV_W-1:0] LAST_VOICE = CV_W'(NUM_VOICES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CV_W-1:0]    r_voice;
    logic [ACC_W-1:0]   r_acc;
    logic [OUT_W-1:0]   r_sample_out;
    logic               r_overrun;
    logic [PHASE_W-1:0] w_phase;
    logic [VOL_W-1:0]   w_vol;
    logic [WSEL_W-1:0]  w_wave;
    logic               w_en;
    logic               w_adv;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_acc_next;
    logic [OUT_W-1:0]   w_scaled;

    wavetable_voice_mixer_regs #(
        .NUM_VOICES (NUM_VOICES),
        .WSEL_W     (WSEL_W),
        .PHASE_W    (PHASE_W),
        .VOL_W      (VOL_W),
        .CV_W       (CV_W)
    ) u_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg),
        .i_rd_voice (r_voice),
        .i_adv      (w_adv),
        .o_phase    (w_phase),
        .o_vol      (w_vol),
        .o_wave     (w_wave),
        .o_en       (w_en)
    );

    assign w_adv      = (r_state == ST_VOICE) && w_en;
    assign w_prod     = PROD_W'(i_rom_data) * PROD_W'(w_vol);
    assign w_acc_next = r_acc + (w_en ? ACC_W'(w_prod) : '0);

    // Left-justify the accumulator into the output word, or keep its top bits when wider.
    if (ACC_W <= OUT_W) begin : g_shift
        assign w_scaled = OUT_W'(w_acc_next) << (OUT_W - ACC_W);
    end else begin : g_trunc
        assign w_scaled = w_acc_next[ACC_W-1 -: OUT_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        o_rom_addr     = '0;
        o_busy         = 1'b1;
        o_sample_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_sample_tick) w_state_next = ST_VOICE;
            end
            ST_VOICE: begin
                o_rom_addr = {w_wave, w_phase[PHASE_W-1 -: ROM_AW]};
                if (r_voice == LAST_VOICE) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                o_sample_valid = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_voice      <= '0;
            r_acc        <= '0;
            r_sample_out <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (i_sample_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (i_sample_tick) begin
                        r_acc   <= '0;
                        r_voice <= '0;
                    end
                end
                ST_VOICE: begin
                    r_acc   <= w_acc_next;
                    r_voice <= r_voice + CV_W'(1);
                    if (r_voice == LAST_VOICE) r_sample_out <= w_scaled;
                end
                default: ;
            endcase
        end
    end

    assign o_sample_out = r_sample_out;
    assign o_overrun    = r_overrun;

endmodule
